mmu_way_join_sync: RTL and testbench
====================================

Name: mmu_way_join_sync

Overview:
- Synchronous join stage directly downstream of the MMU 6-way drive/free splitter.
- Each of the six forked branches performs one TLB-way lookup and signals completion with a 2-phase drive toggle plus bundled result data.
- This block synchronises the six toggles into the clock domain and collects all six results. It resolves hit way, PPN and permissions, presents one valid/ready result, then toggles all six free lines to close the fork's handshake cycle.

Parameters:
NUM_WAYS, 6, number of joined branches (fixed to match the splitter fan-out)
PPN_W, 20, physical page number width per way
PERM_W, 4, permission bits per way
SYNC_STAGES, 2, flops in each toggle synchroniser (min 2)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
i_drive  in  NUM_WAYS  2-phase completion toggle per branch
o_free  out  NUM_WAYS  2-phase free toggle back to each branch
i_hit  in  NUM_WAYS  per-way hit, bundled with i_drive[i]
i_ppn  in  NUM_WAYS*PPN_W  per-way PPN, way i at [i*PPN_W +: PPN_W]
i_perm  in  NUM_WAYS*PERM_W  per-way permissions, same packing
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_hit  out  1  any way hit
o_way  out  3  lowest-index hitting way (0 when no hit)
o_ppn  out  PPN_W  PPN of o_way (0 when no hit)
o_perm  out  PERM_W  perm of o_way (0 when no hit)
o_multi_hit  out  1  more than one way hit
o_proto_err  out  1  sticky: extra toggle on an already-arrived branch

Behaviour:
- Reset, asynchronous and active-high, clears everything:
  - o_free=0, o_valid=0, o_hit/o_way/o_ppn/o_perm/o_multi_hit=0, o_proto_err=0.
  - Synchroniser flops=0, last-level regs=0, arrived mask=0, state=COLLECT.
  - The branches must also be reset so that i_drive=0.
- Arrival: way i has arrived when its synchronised level differs from last_level[i]. On that cycle, capture i_hit[i], i_ppn slice and i_perm slice into per-way holding regs. Set arrived[i] and last_level[i] to the synchronised level.
- Bundled-data rule: branch data is stable before its toggle and stays stable until the matching o_free toggle. Sampling on the detect cycle is therefore safe.
- State machine:
  - COLLECT: accumulate arrivals in any order, including several in the same cycle. When arrived == all ones (including the cycle the last bit is set), go to RESOLVE next cycle.
  - RESOLVE (1 cycle): priority-encode the lowest hitting way. Compute o_multi_hit = popcount(hits) > 1. Register all outputs and set o_valid=1. Go to OUTPUT.
  - OUTPUT: hold o_valid and all result outputs stable until i_ready=1. On the valid&ready cycle, drop o_valid next cycle and go to RELEASE.
  - RELEASE (1 cycle): invert all o_free bits simultaneously, clear arrived, go to COLLECT.
- Latency: the last toggle is first sampled at edge k. Detect occurs at edge k+SYNC_STAGES. o_valid rises at edge k+SYNC_STAGES+2.
- Back-pressure: i_ready may be low indefinitely. The fork is not freed while o_valid=1, so at most one transaction is in flight.
- Protocol error: a toggle detected on a way with arrived[i]=1, in any state, sets o_proto_err until reset. That toggle is otherwise ignored, but last_level is updated.
- o_free toggles only in RELEASE and never per-way.
- Reset mid-operation aborts the transaction and returns to the reset values above. No partial o_free toggle is emitted.

Decomposition:
- Shared package mmu_join_pkg holds:
  - state enum COLLECT/RESOLVE/OUTPUT/RELEASE (2-bit encoding 0..3).
  - NUM_WAYS=6 and the way-index width constant 3.
- One sub-module, mmu_toggle_sync: SYNC_STAGES-deep synchroniser with last-level register and change-pulse output, async active-high reset. Instantiated NUM_WAYS times in a generate loop.

Test Plan:
- Toggle i_drive[0..5] one per cycle; way 3 hits, PPN 0x12345, perm 0xA; i_ready=1 -> o_valid at last-toggle+4 cycles; o_hit=1, o_way=3, o_ppn=0x12345, o_perm=0xA, o_multi_hit=0; o_free goes 0x00->0x3F once.
- All six toggle in the same cycle, no hits -> o_hit=0, o_way=0, o_ppn=0, o_perm=0, o_multi_hit=0; one o_free toggle to 0x3F.
- Ways 1 and 4 hit -> o_way=1, o_ppn = way-1 PPN, o_multi_hit=1.
- i_ready held low 20 cycles -> o_valid and outputs stable for 20 cycles; o_free unchanged until 1 cycle after the ready handshake.
- Way 2 toggles twice before release -> o_proto_err=1 and stays 1; the transaction still completes with the way-2 data from its first arrival.
- Assert rst with four ways arrived -> all outputs 0 immediately; after release, a fresh six-way transaction completes correctly with o_free starting from 0x00.

Source files
------------

// File: rtl/mmu_way_join_sync_pkg.sv
// Shared types and constants for the MMU way-join stage.
package mmu_join_pkg;

  localparam int NUM_WAYS = 6;
  localparam int WAY_W    = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Number of set bits in a way mask; NUM_WAYS fits in WAY_W bits.
  function automatic logic [WAY_W-1:0] popcount(input logic [NUM_WAYS-1:0] mask);
    logic [WAY_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      n = n + WAY_W'(mask[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mmu_way_join_sync_if.sv
// Fork-side toggles/data and consumer-side valid/ready result of the join.
interface mmu_way_join_sync_if #(
  parameter int PPN_W  = 20,
  parameter int PERM_W = 4
);
  import mmu_join_pkg::*;

  logic [NUM_WAYS-1:0]        i_drive;
  logic [NUM_WAYS-1:0]        o_free;
  logic [NUM_WAYS-1:0]        i_hit;
  logic [NUM_WAYS*PPN_W-1:0]  i_ppn;
  logic [NUM_WAYS*PERM_W-1:0] i_perm;
  logic                       o_valid;
  logic                       i_ready;
  logic                       o_hit;
  logic [WAY_W-1:0]           o_way;
  logic [PPN_W-1:0]           o_ppn;
  logic [PERM_W-1:0]          o_perm;
  logic                       o_multi_hit;
  logic                       o_proto_err;

  // Join block view.
  modport slave (
    input  i_drive, i_hit, i_ppn, i_perm, i_ready,
    output o_free, o_valid, o_hit, o_way, o_ppn, o_perm, o_multi_hit, o_proto_err
  );

  // Branches plus consumer view.
  modport master (
    output i_drive, i_hit, i_ppn, i_perm, i_ready,
    input  o_free, o_valid, o_hit, o_way, o_ppn, o_perm, o_multi_hit, o_proto_err
  );

endinterface

// File: rtl/mmu_toggle_sync.sv
// Brings one 2-phase toggle into the clock domain and pulses once per edge.
module mmu_toggle_sync #(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Synchroniser chain plus the last level already seen by the join.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] ^ last_q;

endmodule

// File: rtl/mmu_way_join_sync.sv
// Joins the six TLB-way branches, resolves the hit and frees the fork.
module mmu_way_join_sync
  import mmu_join_pkg::*;
#(
  parameter int PPN_W       = 20,
  parameter int PERM_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  mmu_way_join_sync_if.slave  bus
);

  state_t              state_q, next_state;
  logic [NUM_WAYS-1:0] pulse;
  logic [NUM_WAYS-1:0] arrived_q;
  logic [NUM_WAYS-1:0] hold_hit_q;
  logic [PPN_W-1:0]    hold_ppn_q  [NUM_WAYS];
  logic [PERM_W-1:0]   hold_perm_q [NUM_WAYS];
  logic [WAY_W-1:0]    sel_way;
  logic [PPN_W-1:0]    sel_ppn;
  logic [PERM_W-1:0]   sel_perm;

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_sync
    mmu_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst   (rst),
      .d     (bus.i_drive[g]),
      .pulse (pulse[g])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= next_state;
  end

  // Next-state: collect all six, resolve, wait for the consumer, free the fork.
  always_comb begin
    next_state = state_q;
    case (state_q)
      COLLECT: if (&arrived_q) next_state = RESOLVE;
      RESOLVE: next_state = OUTPUT;
      OUTPUT:  if (bus.i_ready) next_state = RELEASE;
      RELEASE: next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  // Lowest-index hitting way and its data; zeros when nothing hit.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a latch.
    sel_way  = '0;
    sel_ppn  = '0;
    sel_perm = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hold_hit_q[i]) begin
        sel_way  = WAY_W'(i);
        sel_ppn  = hold_ppn_q[i];
        sel_perm = hold_perm_q[i];
      end
    end
  end

  // Arrival capture, protocol checking, result registers and fork release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arrived_q       <= '0;
      hold_hit_q      <= '0;
      // NOTE: the holding array is reset too; it is small and an aborted
      // transaction must not leave stale branch data behind.
      for (int i = 0; i < NUM_WAYS; i++) begin
        hold_ppn_q[i]  <= '0;
        hold_perm_q[i] <= '0;
      end
      bus.o_free      <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_hit       <= 1'b0;
      bus.o_way       <= '0;
      bus.o_ppn       <= '0;
      bus.o_perm      <= '0;
      bus.o_multi_hit <= 1'b0;
      bus.o_proto_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (pulse[i]) begin
          if (arrived_q[i]) begin
            // A second toggle before release is a branch bug; keep first data.
            bus.o_proto_err <= 1'b1;
          end else begin
            arrived_q[i]   <= 1'b1;
            hold_hit_q[i]  <= bus.i_hit[i];
            hold_ppn_q[i]  <= bus.i_ppn[i*PPN_W +: PPN_W];
            hold_perm_q[i] <= bus.i_perm[i*PERM_W +: PERM_W];
          end
        end
      end

      case (state_q)
        RESOLVE: begin
          bus.o_valid     <= 1'b1;
          bus.o_hit       <= |hold_hit_q;
          bus.o_way       <= sel_way;
          bus.o_ppn       <= sel_ppn;
          bus.o_perm      <= sel_perm;
          bus.o_multi_hit <= popcount(hold_hit_q) > WAY_W'(1);
        end
        OUTPUT: begin
          if (bus.i_ready) bus.o_valid <= 1'b0;
        end
        RELEASE: begin
          bus.o_free <= ~bus.o_free;
          arrived_q  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_way_join_sync.sv
// Directed bench with a result scoreboard for mmu_way_join_sync.
module tb_mmu_way_join_sync;
  import mmu_join_pkg::*;

  localparam int PPN_W  = 20;
  localparam int PERM_W = 4;

  typedef struct packed {
    logic        hit;
    logic [2:0]  way;
    logic [19:0] ppn;
    logic [3:0]  perm;
    logic        multi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mmu_way_join_sync_if #(.PPN_W(PPN_W), .PERM_W(PERM_W)) bus ();

  mmu_way_join_sync #(.PPN_W(PPN_W), .PERM_W(PERM_W), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle o_valid is high the outputs must match the head entry.
  always @(negedge clk) begin
    if (!rst && bus.o_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got o_valid=1, expected no pending result at %0t", $time);
      end else begin
        mon_e = exp_q[0];
        check("o_hit",       bus.o_hit,       mon_e.hit);
        check("o_way",       bus.o_way,       mon_e.way);
        check("o_ppn",       bus.o_ppn,       mon_e.ppn);
        check("o_perm",      bus.o_perm,      mon_e.perm);
        check("o_multi_hit", bus.o_multi_hit, mon_e.multi);
        if (bus.i_ready) exp_q.delete(0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_way(input int w, input logic h, input logic [19:0] p, input logic [3:0] m);
    bus.i_hit[w]                   = h;
    bus.i_ppn[w*PPN_W +: PPN_W]    = p;
    bus.i_perm[w*PERM_W +: PERM_W] = m;
  endtask

  // Miss data on every way is non-zero so a leak into the outputs shows up.
  task automatic fill_misses();
    for (int w = 0; w < NUM_WAYS; w++) begin
      set_way(w, 1'b0, 20'hF0000 | 20'(w), 4'hF);
    end
  endtask

  task automatic toggle(input logic [5:0] m);
    bus.i_drive = bus.i_drive ^ m;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.o_valid && cyc < 60);
    if (!bus.o_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout: got o_valid=0 after %0d cycles, expected 1", cyc);
    end
  endtask

  task automatic wait_free(input logic [5:0] e, input string name);
    int c;
    c = 0;
    while (bus.o_free !== e && c < 60) begin
      tick();
      c++;
    end
    check(name, bus.o_free, e);
  endtask

  initial begin
    int cyc;
    bus.i_drive = '0;
    bus.i_hit   = '0;
    bus.i_ppn   = '0;
    bus.i_perm  = '0;
    bus.i_ready = 1'b1;
    rst         = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_valid",     bus.o_valid,     1'b0);
    check("rst_free",      bus.o_free,      6'h00);
    check("rst_proto_err", bus.o_proto_err, 1'b0);
    check("rst_hit",       bus.o_hit,       1'b0);
    check("rst_ppn",       bus.o_ppn,       20'h0);
    rst = 1'b0;
    repeat (2) tick();

    // One toggle per cycle, way 3 hits; check latency and a single free toggle.
    fill_misses();
    set_way(3, 1'b1, 20'h12345, 4'hA);
    exp_q.push_back('{hit: 1'b1, way: 3'd3, ppn: 20'h12345, perm: 4'hA, multi: 1'b0});
    for (int w = 0; w < NUM_WAYS; w++) begin
      toggle(6'(1 << w));
      if (w < NUM_WAYS - 1) tick();
    end
    wait_valid(cyc);
    check("t1_latency", cyc, 5);
    check("t1_free_held", bus.o_free, 6'h00);
    wait_free(6'h3F, "t1_free");
    repeat (5) tick();
    check("t1_free_once", bus.o_free, 6'h3F);

    // All six in the same cycle, no hits.
    fill_misses();
    exp_q.push_back('{hit: 1'b0, way: 3'd0, ppn: 20'h0, perm: 4'h0, multi: 1'b0});
    toggle(6'h3F);
    wait_valid(cyc);
    wait_free(6'h00, "t2_free");

    // Ways 1 and 4 hit: lowest wins, multi-hit flagged.
    fill_misses();
    set_way(1, 1'b1, 20'h11111, 4'h5);
    set_way(4, 1'b1, 20'h44444, 4'h9);
    exp_q.push_back('{hit: 1'b1, way: 3'd1, ppn: 20'h11111, perm: 4'h5, multi: 1'b1});
    toggle(6'h3F);
    wait_valid(cyc);
    wait_free(6'h3F, "t3_free");

    // Back-pressure: consumer stalls for 20 cycles.
    fill_misses();
    set_way(5, 1'b1, 20'hABCDE, 4'h3);
    bus.i_ready = 1'b0;
    exp_q.push_back('{hit: 1'b1, way: 3'd5, ppn: 20'hABCDE, perm: 4'h3, multi: 1'b0});
    toggle(6'h3F);
    wait_valid(cyc);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t4_valid_held", bus.o_valid, 1'b1);
      check("t4_free_held",  bus.o_free,  6'h3F);
    end
    bus.i_ready = 1'b1;
    tick();
    check("t4_valid_drop",  bus.o_valid, 1'b0);
    check("t4_free_before", bus.o_free,  6'h3F);
    tick();
    check("t4_free_after",  bus.o_free,  6'h00);

    // Way 2 toggles twice: sticky error, first-arrival data kept.
    fill_misses();
    set_way(2, 1'b1, 20'h22222, 4'h6);
    check("t5_err_before", bus.o_proto_err, 1'b0);
    exp_q.push_back('{hit: 1'b1, way: 3'd2, ppn: 20'h22222, perm: 4'h6, multi: 1'b0});
    toggle(6'h04);
    repeat (5) tick();
    set_way(2, 1'b1, 20'h99999, 4'hF);
    toggle(6'h04);
    repeat (5) tick();
    check("t5_err_set", bus.o_proto_err, 1'b1);
    toggle(6'h3B);
    wait_valid(cyc);
    wait_free(6'h3F, "t5_free");
    repeat (3) tick();
    check("t5_err_sticky", bus.o_proto_err, 1'b1);

    // Reset with four ways arrived, then a fresh transaction.
    fill_misses();
    toggle(6'h0F);
    repeat (5) tick();
    check("t6_no_valid", bus.o_valid, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_free",  bus.o_free,      6'h00);
    check("t6_rst_err",   bus.o_proto_err, 1'b0);
    check("t6_rst_valid", bus.o_valid,     1'b0);
    check("t6_rst_way",   bus.o_way,       3'd0);
    bus.i_drive = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    fill_misses();
    set_way(0, 1'b1, 20'h0F0F0, 4'hC);
    set_way(5, 1'b1, 20'h55555, 4'h1);
    exp_q.push_back('{hit: 1'b1, way: 3'd0, ppn: 20'h0F0F0, perm: 4'hC, multi: 1'b1});
    toggle(6'h3F);
    wait_valid(cyc);
    check("t6_latency", cyc, 5);
    wait_free(6'h3F, "t6_free");

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

endmodule
